// File: rtl/inst_fetch.sv
// Instruction fetch front-end: walks a PC over a zero-latency ROM port and
// buffers fetched words in a small prefetch queue.
// Decode consumes the queue over a valid/ready handshake.
module inst_fetch #(
  parameter int AW        = 10,
  parameter int IW        = 9,
  parameter int DEPTH     = 2,
  parameter int LAST_ADDR = 511
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [AW-1:0] StartAddr,
  output logic [AW-1:0] InstAddress,
  input  logic [IW-1:0] InstOut,
  input  logic          Redirect,
  input  logic [AW-1:0] RedirectAddr,
  output logic          InstValid,
  input  logic          InstReady,
  output logic [IW-1:0] Inst,
  output logic [AW-1:0] InstPC,
  output logic          Done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW-1:0] LAST = AW'(LAST_ADDR);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [1:0]    state, state_nxt;
  logic [AW-1:0] pc, pc_nxt;
  logic [IW-1:0] q_instr [DEPTH];
  logic [AW-1:0] q_pc    [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [IW-1:0] hold_instr;
  logic [AW-1:0] hold_pc;
  logic          redir, push, pop, head_vld;

  assign head_vld    = (count != '0);
  assign InstValid   = head_vld;
  assign InstAddress = pc;
  assign Done        = (state == S_DONE);

  // Outputs keep the last head seen once the queue runs empty.
  assign Inst   = head_vld ? q_instr[rd_ptr] : hold_instr;
  assign InstPC = head_vld ? q_pc[rd_ptr]    : hold_pc;

  assign redir = Redirect & ((state == S_FETCH) | (state == S_DRAIN));
  assign pop   = head_vld & InstReady & ~redir;
  assign push  = (state == S_FETCH) & ((count < FULL) | (head_vld & InstReady)) & ~redir;

  always_comb begin
    count_nxt = count;
    if (redir)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = count + CW'(1);
    else if (pop && !push)
      count_nxt = count - CW'(1);
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (redir) begin
      pc_nxt    = RedirectAddr;
      state_nxt = (RedirectAddr > LAST) ? S_DRAIN : S_FETCH;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            pc_nxt    = StartAddr;
            state_nxt = (StartAddr > LAST) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          // PC parks on the last address so it can never wrap.
          if (push) begin
            if (pc == LAST)
              state_nxt = S_DRAIN;
            else
              pc_nxt = pc + AW'(1);
          end
        end
        S_DRAIN: begin
          if (count_nxt == '0)
            state_nxt = S_DONE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Control and queue state
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      hold_instr <= '0;
      hold_pc    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      count <= count_nxt;
      if (head_vld) begin
        hold_instr <= q_instr[rd_ptr];
        hold_pc    <= q_pc[rd_ptr];
      end
      if (redir) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          q_instr[wr_ptr] <= InstOut;
          q_pc[wr_ptr]    <= pc;
          wr_ptr          <= wr_ptr + PW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch front-end that drives the instruction ROM's combinational read port (10-bit address in, 9-bit instruction out, zero-latency read).
- Walks a program counter and buffers fetched words in a small prefetch queue.
- Presents instructions to decode over a valid/ready handshake.
- Supports start, redirect (branch/jump) with queue flush, and end-of-program drain/done signalling.

Parameters:
AW, 10, ROM address width; PC width.
IW, 9, instruction width.
DEPTH, 2, prefetch queue entries (power of 2, >=2).
LAST_ADDR, 511, final fetchable address; fetch stops after this word is pushed.

Ports:
Clk  input  1  rising-edge clock.
Reset_n  input  1  asynchronous, active-low reset.
Start  input  1  one-cycle pulse; begins fetching at StartAddr; honoured only in IDLE or DONE.
StartAddr  input  AW  first fetch address, sampled with Start.
InstAddress  output  AW  address to ROM; always equals PC register.
InstOut  input  IW  ROM data for InstAddress, valid in the same cycle.
Redirect  input  1  one-cycle pulse; flush queue and refetch from RedirectAddr.
RedirectAddr  input  AW  new PC, sampled with Redirect.
InstValid  output  1  queue head holds a valid instruction.
InstReady  input  1  decode accepts head this cycle.
Inst  output  IW  head instruction.
InstPC  output  AW  address the head instruction was fetched from.
Done  output  1  high in DONE state.

Behaviour:
- Reset (async assert, sync-to-Clk release): state=IDLE, PC=0, queue count=0, all entries 0, InstValid=0, Done=0, InstAddress=0.
- Storage: queue of DEPTH entries {IW instr, AW pc}, with rd/wr pointers and count 0..DEPTH.
  - Inst/InstPC come from the head entry. InstValid = (count!=0).
  - Inst/InstPC hold their last head value when count=0.
- Pop = InstValid & InstReady.
- Push = (state==FETCH) & (count<DEPTH | Pop). Push writes {InstOut, PC}. Simultaneous push+pop on a full queue is legal; count is unchanged.
- States:
  - IDLE: no push. Start -> PC<=StartAddr, go FETCH. If StartAddr>LAST_ADDR, go DONE instead.
  - FETCH: on a push, if PC==LAST_ADDR go DRAIN with PC held; otherwise PC<=PC+1. With no push (queue full, no pop), PC holds.
  - DRAIN: no push. Pops continue. Go DONE when count reaches 0, including the cycle in which the last pop makes count 0.
  - DONE: Done=1. Start behaves as in IDLE (restart). Redirect is ignored.
- Redirect: accepted in FETCH and DRAIN only; ignored in IDLE and DONE.
  - Highest priority in that cycle: any push and pop are suppressed, the queue is flushed (count<=0, pointers<=0), and PC<=RedirectAddr.
  - Next state is FETCH, or DRAIN if RedirectAddr>LAST_ADDR. A DRAIN reached this way has count 0, so it goes DONE next cycle.
  - InstValid is 0 in the cycle after Redirect.
  - Decode must not count a Pop in the Redirect cycle as accepted.
- Start while in FETCH/DRAIN: ignored.
- Start and Redirect in the same cycle: Redirect wins if the state accepts it; otherwise Start applies.
- Latency:
  - Start at cycle N -> first InstValid at N+2 (PC loads at N+1, push at N+1, visible at N+2).
  - Redirect has the same 2-cycle bubble.
  - Steady state with InstReady=1: one instruction per cycle.
- PC arithmetic: AW-bit unsigned. It never increments past LAST_ADDR, so there is no wrap.
- Reset mid-operation: immediate return to reset values regardless of state or queue contents.

Test Plan:
- ROM[k]=k (mod 512), Start with StartAddr=5, InstReady=1 -> InstValid rises 2 cycles after Start; Inst/InstPC = 5,6,7,... one per cycle; InstAddress increments each cycle.
- Hold InstReady=0 after Start with StartAddr=0 -> count fills to 2 with PCs 0,1; PC/InstAddress stick at 2. Then InstReady=1 -> stream 0,1,2,3 with no gaps or duplicates.
- LAST_ADDR=9, StartAddr=7, InstReady=1 -> delivers 7,8,9. DRAIN lasts until the queue empties; Done=1 exactly one cycle after the pop of 9. Then Start with StartAddr=0 restarts from 0.
- Full queue holding PCs 3,4 with InstReady=0; Redirect to 20 -> queue flushed; InstValid=0 next cycle; the next delivered InstPC is 20, then 21. Neither 3 nor 4 is ever accepted.
- Redirect and Start asserted together in FETCH -> Redirect applied, Start ignored. Redirect pulsed in IDLE -> no state change; InstAddress stays 0.
- Deassert Reset_n asynchronously mid-stream (count=2, PC=40) -> outputs go to reset values immediately without waiting for a clock edge. After release, stays IDLE with InstValid=0 until the next Start.
